// File: rtl/video_pkg.sv
// Video subsystem shared definitions: fetch-sequencer phase encodings and the
// field layout of a text-memory word.
package video_pkg;

    typedef enum logic [1:0] {
        TEXT_FETCH  = 2'd0,
        GLYPH_FETCH = 2'd1,
        SET_COLOR   = 2'd2,
        DRAW        = 2'd3
    } phase_e;

    // Text word: [15:12] background index, [11:8] foreground index, [7:0] char code.
    localparam int unsigned TW_BG_LSB   = 12;
    localparam int unsigned TW_FG_LSB   = 8;
    localparam int unsigned TW_CHAR_LSB = 0;
    localparam int unsigned TW_ATTR_LSB = 8;

    function automatic logic [7:0] tw_char(input logic [15:0] word);
        return word[TW_CHAR_LSB +: 8];
    endfunction

    function automatic logic [7:0] tw_attr(input logic [15:0] word);
        return word[TW_ATTR_LSB +: 8];
    endfunction

endpackage

// File: rtl/palette_regfile.sv
// 16-entry x 8-bit colour palette: synchronous write, two asynchronous read
// ports, entry i resets to {i, i}.
module palette_regfile (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       we,
    input  logic [3:0] widx,
    input  logic [7:0] wdata,
    input  logic [3:0] fg_idx,
    input  logic [3:0] bg_idx,
    output logic [7:0] fg_data,
    output logic [7:0] bg_data
);

    logic [7:0] regs_q [16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= {4'(i), 4'(i)};
            end
        end else if (we) begin
            regs_q[widx] <= wdata;
        end
    end

    assign fg_data = regs_q[fg_idx];
    assign bg_data = regs_q[bg_idx];

endmodule

// File: rtl/text_pixel_generator.sv
// Text-mode pixel generator: 4-phase fetch of text word and glyph row, palette
// lookup and blinking cursor overlay, producing one registered colour per pixel.
module text_pixel_generator
    import video_pkg::*;
#(
    parameter int unsigned PIX_W      = 10,
    parameter int unsigned LINE_W     = 9,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned TEXT_BASE  = 0,
    parameter int unsigned GLYPH_BASE = 8192,
    parameter int unsigned BLINK_LOG2 = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [PIX_W-1:0]  pixel_counter,
    input  logic [LINE_W-1:0] line_counter,
    input  logic              frame_start,
    input  logic [15:0]       pg_data,
    output logic [ADDR_W-1:0] pg_addr,
    output logic [7:0]        color,
    output logic [1:0]        phase,
    input  logic              pal_we,
    input  logic [3:0]        pal_idx,
    input  logic [7:0]        pal_wdata,
    input  logic              cursor_en,
    input  logic              cursor_mode,
    input  logic              cursor_blink,
    input  logic [PIX_W-4:0]  cursor_col,
    input  logic [LINE_W-4:0] cursor_row
);

    phase_e                phase_q;
    logic [7:0]            color_q;
    logic [7:0]            attr_q;
    logic [BLINK_LOG2-1:0] blink_cnt_q;

    logic [PIX_W-4:0]  cell_col;
    logic [LINE_W-4:0] cell_row;
    logic [ADDR_W-1:0] text_addr;
    logic [ADDR_W-1:0] glyph_addr;
    logic              glyph_bit;
    logic              cursor_hit;
    logic              cursor_vis;
    logic              pix_on;
    logic [7:0]        fg_color;
    logic [7:0]        bg_color;

    assign cell_col = pixel_counter[PIX_W-1:3];
    assign cell_row = line_counter[LINE_W-1:3];

    assign text_addr  = ADDR_W'(TEXT_BASE) + ADDR_W'({cell_row, cell_col});
    // Glyph fetch uses the text word returned in this cycle, not a latched copy.
    assign glyph_addr = ADDR_W'(GLYPH_BASE) + ADDR_W'({tw_char(pg_data), 2'b00})
                      + ADDR_W'(line_counter[2:1]);

    always_comb begin
        pg_addr = '0;
        case (phase_q)
            TEXT_FETCH:  pg_addr = text_addr;
            GLYPH_FETCH: pg_addr = glyph_addr;
            default:     pg_addr = '0;
        endcase
    end

    // Each glyph word packs two rows: even line in the high byte, odd in the low.
    assign glyph_bit  = pg_data[{~line_counter[0], pixel_counter[2:0]}];
    assign cursor_hit = cursor_en && (cell_row == cursor_row) && (cell_col == cursor_col)
                      && (cursor_mode || (line_counter[2:1] == 2'b11));
    assign cursor_vis = cursor_hit && (!cursor_blink || blink_cnt_q[BLINK_LOG2-1]);
    assign pix_on     = glyph_bit ^ cursor_vis;

    palette_regfile u_palette (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (pal_we),
        .widx    (pal_idx),
        .wdata   (pal_wdata),
        .fg_idx  (attr_q[3:0]),
        .bg_idx  (attr_q[7:4]),
        .fg_data (fg_color),
        .bg_data (bg_color)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= TEXT_FETCH;
            color_q <= 8'h00;
            attr_q  <= 8'h00;
        end else if (!enable) begin
            phase_q <= TEXT_FETCH;
            color_q <= 8'h00;
        end else begin
            case (phase_q)
                TEXT_FETCH: begin
                    phase_q <= GLYPH_FETCH;
                end
                GLYPH_FETCH: begin
                    attr_q  <= tw_attr(pg_data);
                    phase_q <= SET_COLOR;
                end
                SET_COLOR: begin
                    color_q <= pix_on ? fg_color : bg_color;
                    phase_q <= DRAW;
                end
                default: begin
                    phase_q <= TEXT_FETCH;
                end
            endcase
        end
    end

    // Free-running frame counter; independent of enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
        end else if (frame_start) begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign color = color_q;
    assign phase = phase_q;

endmodule

// File: tb/tb_text_pixel_generator.sv
// Directed bench for text_pixel_generator with a registered memory model and an
// expected-colour scoreboard queue.
module tb_text_pixel_generator;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [9:0]  pixel_counter;
    logic [8:0]  line_counter;
    logic        frame_start;
    logic [15:0] pg_data;
    logic [14:0] pg_addr;
    logic [7:0]  color;
    logic [1:0]  phase;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [7:0]  pal_wdata;
    logic        cursor_en;
    logic        cursor_mode;
    logic        cursor_blink;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;

    logic [15:0] mem [32768];
    logic [7:0]  exp_q [$];
    int          checks;
    int          failures;

    text_pixel_generator dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .pixel_counter (pixel_counter),
        .line_counter  (line_counter),
        .frame_start   (frame_start),
        .pg_data       (pg_data),
        .pg_addr       (pg_addr),
        .color         (color),
        .phase         (phase),
        .pal_we        (pal_we),
        .pal_idx       (pal_idx),
        .pal_wdata     (pal_wdata),
        .cursor_en     (cursor_en),
        .cursor_mode   (cursor_mode),
        .cursor_blink  (cursor_blink),
        .cursor_col    (cursor_col),
        .cursor_row    (cursor_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data valid one cycle after the address.
    always @(posedge clk) pg_data <= mem[pg_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_phase(input string tag, input logic [1:0] ph);
        int n;
        n = 0;
        while (phase !== ph && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (phase !== ph) check({tag, "_timeout"}, 32'(phase), 32'(ph));
    endtask

    task automatic pal_write(input logic [3:0] idx, input logic [7:0] data);
        @(negedge clk);
        pal_we = 1'b1; pal_idx = idx; pal_wdata = data;
        @(negedge clk);
        pal_we = 1'b0;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    // One full pixel: set counters at DRAW, check both fetch addresses, optionally
    // write palette entry 14 / pulse frame_start during SET_COLOR, check colour.
    task automatic do_pixel(input string tag, input logic [9:0] px, input logic [8:0] ln,
                            input logic [7:0] exp_col, input bit pw, input logic [7:0] pwd,
                            input bit fs);
        int   ta;
        int   ga;
        logic [15:0] tword;
        wait_phase(tag, 2'd3);
        pixel_counter = px;
        line_counter  = ln;
        exp_q.push_back(exp_col);
        ta = (int'(ln) / 8) * 128 + int'(px) / 8;
        tword = mem[ta];
        ga = 8192 + int'(tword[7:0]) * 4 + ((int'(ln) / 2) % 4);
        @(negedge clk);
        check({tag, "_text_addr"}, 32'(pg_addr), 32'(ta));
        @(negedge clk);
        check({tag, "_glyph_addr"}, 32'(pg_addr), 32'(ga));
        @(negedge clk);
        if (pw) begin
            pal_we = 1'b1; pal_idx = 4'd14; pal_wdata = pwd;
        end
        if (fs) frame_start = 1'b1;
        @(negedge clk);
        pal_we = 1'b0;
        frame_start = 1'b0;
        check({tag, "_color"}, 32'(color), 32'(exp_q.pop_front()));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[130]  = 16'h1E41;
        mem[131]  = 16'h2341;
        mem[8453] = 16'h0200;
        mem[8455] = 16'h0200;

        reset_n = 1'b0; enable = 1'b1; pixel_counter = 10'd17; line_counter = 9'd10;
        frame_start = 1'b0; pal_we = 1'b0; pal_idx = 4'd0; pal_wdata = 8'h00;
        cursor_en = 1'b0; cursor_mode = 1'b0; cursor_blink = 1'b0;
        cursor_col = 7'd2; cursor_row = 6'd1;

        repeat (3) @(negedge clk);
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_color", 32'(color), 32'h00);
        check("reset_addr", 32'(pg_addr), 32'd130);
        reset_n = 1'b1;

        do_pixel("fetch_ee", 10'd17, 9'd10, 8'hEE, 1'b0, 8'h00, 1'b0);

        // Mid-sequence asynchronous reset.
        @(negedge clk);
        wait_phase("rst_mid", 2'd2);
        reset_n = 1'b0;
        #1;
        check("rst_mid_color", 32'(color), 32'h00);
        check("rst_mid_phase", 32'(phase), 32'd0);
        check("rst_mid_addr", 32'(pg_addr), 32'd130);
        @(negedge clk);
        reset_n = 1'b1;

        mem[8453] = 16'h0000;
        do_pixel("glyph_zero", 10'd17, 9'd10, 8'h11, 1'b0, 8'h00, 1'b0);
        mem[8453] = 16'h0200;

        pal_write(4'd14, 8'h3C);
        do_pixel("pal_write", 10'd17, 9'd10, 8'h3C, 1'b0, 8'h00, 1'b0);
        do_pixel("pal_same_cycle", 10'd17, 9'd10, 8'h3C, 1'b1, 8'h55, 1'b0);
        do_pixel("pal_after", 10'd17, 9'd10, 8'h55, 1'b0, 8'h00, 1'b0);
        do_pixel("odd_line", 10'd17, 9'd11, 8'h11, 1'b0, 8'h00, 1'b0);
        do_pixel("cell_131", 10'd25, 9'd10, 8'h33, 1'b0, 8'h00, 1'b0);

        cursor_en = 1'b1;
        do_pixel("cur_ul_hit", 10'd17, 9'd14, 8'h11, 1'b0, 8'h00, 1'b0);
        do_pixel("cur_ul_miss", 10'd17, 9'd10, 8'h55, 1'b0, 8'h00, 1'b0);
        cursor_mode = 1'b1;
        do_pixel("cur_blk_hit", 10'd17, 9'd10, 8'h11, 1'b0, 8'h00, 1'b0);
        do_pixel("cur_blk_cell", 10'd25, 9'd10, 8'h33, 1'b0, 8'h00, 1'b0);

        cursor_blink = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            do_pixel($sformatf("blink_%0d", k), 10'd17, 9'd10,
                     (k >= 16 && k < 32) ? 8'h11 : 8'h55, 1'b0, 8'h00, k == 15);
            if (k != 15) pulse_frame();
        end

        // Enable drop in GLYPH_FETCH, then re-enable.
        cursor_en = 1'b0;
        do_pixel("pre_drop", 10'd17, 9'd10, 8'h55, 1'b0, 8'h00, 1'b0);
        wait_phase("drop", 2'd1);
        enable = 1'b0;
        @(posedge clk); #1;
        check("drop_color", 32'(color), 32'h00);
        check("drop_phase", 32'(phase), 32'd0);
        repeat (2) @(negedge clk);
        check("drop_hold_phase", 32'(phase), 32'd0);
        enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reen_2_color", 32'(color), 32'h00);
        @(posedge clk); #1;
        check("reen_3_color", 32'(color), 32'h55);
        check("reen_3_phase", 32'(phase), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/text_pixel_generator.md
# text_pixel_generator

Parametrised text-mode pixel generator that turns VGA pixel/line counters into an 8-bit colour per pixel. It fetches a 16-bit character word from text memory, then the matching glyph row, and selects a foreground or background colour from a 16-entry writable palette. It also overlays a blinking hardware cursor. It sits between the VGA timing generator and the shared video-memory read port, and owns its own 4-phase fetch sequencer.

## Interface
- `PIX_W`, 10, pixel_counter width
- `LINE_W`, 9, line_counter width
- `ADDR_W`, 15, memory address width
- `TEXT_BASE`, 0, word address of the text area
- `GLYPH_BASE`, 8192, word address of the glyph area (256 glyphs × 4 words)
- `BLINK_LOG2`, 5, blink period = 2^BLINK_LOG2 frames
- `clk`  in  1  system clock, 4× pixel rate
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  generator active; low forces black and a phase restart
- `pixel_counter`  in  PIX_W  current pixel x, stable for all 4 phases of a pixel
- `line_counter`  in  LINE_W  current line y
- `frame_start`  in  1  one-cycle pulse per frame; advances the blink counter
- `pg_data`  in  16  memory read data, valid one cycle after `pg_addr`
- `pg_addr`  out  ADDR_W  memory read address (combinational from phase and counters)
- `color`  out  8  registered pixel colour
- `phase`  out  2  current sequencer phase, for timing alignment
- `pal_we`  in  1  palette write strobe
- `pal_idx`  in  4  palette entry to write
- `pal_wdata`  in  8  palette write data
- `cursor_en`  in  1  cursor enable
- `cursor_mode`  in  1  0 = underline (glyph rows 6–7), 1 = full block
- `cursor_blink`  in  1  1 = cursor gated by blink phase; 0 = cursor steady
- `cursor_col`  in  PIX_W-3  cursor cell column
- `cursor_row`  in  LINE_W-3  cursor cell row

## Operation
- Phase FSM, 2 bits: TEXT_FETCH(0) → GLYPH_FETCH(1) → SET_COLOR(2) → DRAW(3) → TEXT_FETCH. It advances every clock while `enable` is high. While `enable` is low it is held at TEXT_FETCH.
- TEXT_FETCH: `pg_addr` = TEXT_BASE + {line_counter[LINE_W-1:3], pixel_counter[PIX_W-1:3]}.
- GLYPH_FETCH: `pg_data` holds the text word: [15:12] bg index, [11:8] fg index, [7:0] char code.
  - Latch bits [15:8] into `attr_q`.
  - `pg_addr` = GLYPH_BASE + {char, 2'b00} + line_counter[2:1].
- SET_COLOR: `pg_data` holds the glyph word. Even lines use the high byte, odd lines the low byte.
  - bit = pg_data[{~line_counter[0], pixel_counter[2:0]}].
  - on = bit XOR cursor_vis.
  - `color` ← on ? pal[fg] : pal[bg].
- DRAW: `color` holds its value. `pg_addr` = 0 in SET_COLOR and DRAW.
- cursor_hit requires all of:
  - `cursor_en` high;
  - the cell matches `cursor_row`/`cursor_col`;
  - `cursor_mode` = 1, or line_counter[2:1] = 2'b11.
- cursor_vis = cursor_hit AND (~`cursor_blink` OR blink_cnt[BLINK_LOG2-1]).
- blink_cnt (BLINK_LOG2 bits) increments on each `frame_start` and wraps modulo 2^BLINK_LOG2. It counts regardless of `enable`.
- Palette: 16 × 8 registers. A `pal_we` write takes effect at the clock edge and is accepted in any phase and with `enable` low.
  - A write and a SET_COLOR read of the same entry in the same cycle: the read sees the old value.
- Address arithmetic is done at ADDR_W bits; overflow wraps modulo 2^ADDR_W.

## Timing
- Reset (async, `reset_n` low): phase = 0, `color` = 8'h00, `attr_q` = 0, blink_cnt = 0, palette entry i = {i, i} (so 0→8'h00, 7→8'h77, 15→8'hFF).
- `pg_addr` for phase n is presented in cycle n. The returned data is consumed in cycle n+1.
- `color` updates at the end of SET_COLOR. It is stable from DRAW through the next SET_COLOR, i.e. one pixel of latency relative to the counters.
- `enable` falling mid-sequence: next edge `color` = 0 and phase = TEXT_FETCH. On re-enable, the first valid colour appears after SET_COLOR, 3 edges later.
- `frame_start` coinciding with SET_COLOR: the colour uses the pre-increment blink_cnt.

## Structure
- Shared package `video_pkg`: the phase encodings (TEXT_FETCH, GLYPH_FETCH, SET_COLOR, DRAW) and the text-word field positions, also used by the timing generator and the text writer.
- One sub-module, `palette_regfile`: 16×8 registers with a synchronous write, an asynchronous read, and reset to {i,i}.

## Test plan
- Reset: hold `reset_n` low mid-phase → `color` = 8'h00, `phase` = 0, `pg_addr` = TEXT_BASE + cell address.
- Fetch path: pixel 17, line 10 → TEXT_FETCH addr 130. Return 16'h1E41 → GLYPH_FETCH addr 8453. Return 16'h0200 → `color` = 8'hEE after SET_COLOR; with glyph word 16'h0000 → 8'h11.
- Palette: write idx 14 = 8'h3C; repeat the fetch above → `color` = 8'h3C. Write idx 14 during SET_COLOR → that pixel still shows the old value.
- Cursor: cursor at col 2, row 1, mode 0. Line 14 → colour inverted; line 10 → not inverted. Mode 1 → inverted on line 10.
- Blink: `cursor_blink` = 1, BLINK_LOG2 = 5. Cursor hidden for `frame_start` pulses 0–15, shown for 16–31, hidden again at 32.
- Enable drop: deassert `enable` in GLYPH_FETCH → next edge `color` = 0 and phase = 0. Re-enable → correct colour after 3 edges.
